// File: rtl/gdout_pkg.sv
// Shared defaults and sizing helper for the multi-plane graphic serializer.
package gdout_pkg;

    localparam int NPLANE_DEF = 3;
    localparam int WORD_DEF   = 8;

    function automatic int bitcnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/gdout_plane.sv
// One plane of the serializer: prefetch hold word, shift register and dot tap.
module gdout_plane
    import gdout_pkg::*;
#(
    parameter int WORD      = WORD_DEF,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_hold_i,
    input  logic [WORD-1:0] data_i,
    input  logic            take_i,
    input  logic            shift_i,
    input  logic            clear_i,
    output logic            tap_o
);

    logic [WORD-1:0] hold_q, hold_d;
    logic [WORD-1:0] sh_q, sh_d;

    // Next-state for hold and shifter; take reads the old hold while a new word lands.
    always_comb begin
        hold_d = hold_q;
        sh_d   = sh_q;
        if (load_hold_i) begin
            hold_d = data_i;
        end else begin
            hold_d = hold_q;
        end
        if (clear_i) begin
            sh_d = '0;
        end else if (take_i) begin
            sh_d = hold_q;
        end else if (shift_i) begin
            sh_d = LSB_FIRST ? (sh_q >> 1'b1) : (sh_q << 1'b1);
        end else begin
            sh_d = sh_q;
        end
    end

    // Plane state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q <= '0;
            sh_q   <= '0;
        end else begin
            hold_q <= hold_d;
            sh_q   <= sh_d;
        end
    end

    assign tap_o = LSB_FIRST ? sh_q[0] : sh_q[WORD-1];

endmodule

// File: rtl/gdout_mp.sv
// Multi-plane graphic serializer: one-deep prefetch hold, blank-time priming,
// NPLANE dot streams at dot clock or half dot clock with sticky underrun flag.
module gdout_mp
    import gdout_pkg::*;
#(
    parameter int NPLANE    = NPLANE_DEF,
    parameter int WORD      = WORD_DEF,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   nHBLANK,
    input  logic                   nVBLANK,
    input  logic                   DWIDE,
    input  logic [NPLANE*WORD-1:0] DATA,
    input  logic                   DVALID,
    output logic                   DRDY,
    input  logic                   UCLR,
    output logic [NPLANE-1:0]      GDAT,
    output logic                   UNDERRUN
);

    localparam int            BW   = bitcnt_w(WORD);
    localparam logic [BW-1:0] LAST = BW'(WORD - 1);

    logic          hold_full_q, hold_full_d;
    logic          primed_q, primed_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic          phase_q, phase_d;
    logic          wide_q, wide_d;
    logic          was_active_q;
    logic          underrun_q, underrun_d;

    logic              active_s, step_s, accept_s;
    logic              take_s, shift_s, clear_s, urun_set_s;
    logic [NPLANE-1:0] tap_s;

    assign active_s = nHBLANK & nVBLANK;
    assign step_s   = ~wide_q | phase_q;
    assign DRDY     = ~hold_full_q | take_s;
    assign accept_s = DVALID & DRDY;

    // Sequencing: priming in blank, dot stepping and word boundaries in active.
    always_comb begin
        take_s     = 1'b0;
        shift_s    = 1'b0;
        clear_s    = 1'b0;
        urun_set_s = 1'b0;
        primed_d   = primed_q;
        bitcnt_d   = bitcnt_q;
        phase_d    = phase_q;
        wide_d     = wide_q;
        if (!active_s) begin
            bitcnt_d = '0;
            phase_d  = 1'b0;
            wide_d   = DWIDE;
            // First blank clock after a line throws away the partial word.
            if (was_active_q) begin
                primed_d = 1'b0;
                clear_s  = 1'b1;
            end else if (!primed_q && hold_full_q) begin
                primed_d = 1'b1;
                take_s   = 1'b1;
            end else begin
                primed_d = primed_q;
            end
        end else begin
            phase_d = wide_q ? ~phase_q : 1'b0;
            if (!was_active_q && !primed_q) begin
                urun_set_s = 1'b1;
            end else begin
                urun_set_s = 1'b0;
            end
            if (step_s && (bitcnt_q == LAST)) begin
                bitcnt_d = '0;
                if (hold_full_q) begin
                    take_s   = 1'b1;
                    primed_d = 1'b1;
                end else begin
                    clear_s    = 1'b1;
                    primed_d   = 1'b0;
                    urun_set_s = 1'b1;
                end
            end else if (step_s) begin
                shift_s  = 1'b1;
                bitcnt_d = bitcnt_q + BW'(1);
            end else begin
                bitcnt_d = bitcnt_q;
            end
        end
    end

    // Hold occupancy and sticky underrun; a set wins over a same-cycle clear.
    always_comb begin
        hold_full_d = hold_full_q;
        underrun_d  = underrun_q;
        if (accept_s) begin
            hold_full_d = 1'b1;
        end else if (take_s) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end
        if (urun_set_s) begin
            underrun_d = 1'b1;
        end else if (UCLR) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    // Control registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_full_q  <= 1'b0;
            primed_q     <= 1'b0;
            bitcnt_q     <= '0;
            phase_q      <= 1'b0;
            wide_q       <= 1'b0;
            was_active_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            hold_full_q  <= hold_full_d;
            primed_q     <= primed_d;
            bitcnt_q     <= bitcnt_d;
            phase_q      <= phase_d;
            wide_q       <= wide_d;
            was_active_q <= active_s;
            underrun_q   <= underrun_d;
        end
    end

    for (genvar p = 0; p < NPLANE; p++) begin : g_plane
        gdout_plane #(
            .WORD      (WORD),
            .LSB_FIRST (LSB_FIRST)
        ) u_plane (
            .clk_i       (CLK),
            .rst_i       (RST),
            .load_hold_i (accept_s),
            .data_i      (DATA[p*WORD +: WORD]),
            .take_i      (take_s),
            .shift_i     (shift_s),
            .clear_i     (clear_s),
            .tap_o       (tap_s[p])
        );
    end

    assign GDAT     = {NPLANE{active_s & primed_q}} & tap_s;
    assign UNDERRUN = underrun_q;

endmodule

// File: tb/tb_gdout_mp.sv
// Scoreboard bench for gdout_mp: an LSB-first and an MSB-first instance share stimulus.
module tb_gdout_mp;

    localparam int NP = 3;
    localparam int W  = 8;

    typedef struct packed {
        logic [NP-1:0] l;
        logic [NP-1:0] m;
    } exp_t;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            nHBLANK = 1'b0;
    logic            nVBLANK = 1'b1;
    logic            DWIDE = 1'b0;
    logic [NP*W-1:0] DATA = '0;
    logic            DVALID = 1'b0;
    logic            UCLR = 1'b0;
    logic            DRDY, DRDY_M, UNDERRUN, UNDERRUN_M;
    logic [NP-1:0]   GDAT, GDAT_M;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    gdout_mp #(.NPLANE(NP), .WORD(W), .LSB_FIRST(1'b1)) dut (
        .CLK(CLK), .RST(RST), .nHBLANK(nHBLANK), .nVBLANK(nVBLANK), .DWIDE(DWIDE),
        .DATA(DATA), .DVALID(DVALID), .DRDY(DRDY), .UCLR(UCLR), .GDAT(GDAT),
        .UNDERRUN(UNDERRUN)
    );

    gdout_mp #(.NPLANE(NP), .WORD(W), .LSB_FIRST(1'b0)) dut_m (
        .CLK(CLK), .RST(RST), .nHBLANK(nHBLANK), .nVBLANK(nVBLANK), .DWIDE(DWIDE),
        .DATA(DATA), .DVALID(DVALID), .DRDY(DRDY_M), .UCLR(UCLR), .GDAT(GDAT_M),
        .UNDERRUN(UNDERRUN_M)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_word(input logic [NP*W-1:0] d);
        int t = 0;
        while (!DRDY && t < 20) begin
            tick();
            t++;
        end
        if (!DRDY) begin
            failures++;
            $display("FAIL load_timeout: DRDY=%b required 1", DRDY);
        end
        DVALID = 1'b1;
        DATA   = d;
        tick();
        DVALID = 1'b0;
    endtask

    task automatic push_dots(input logic [NP*W-1:0] d, input bit wide, input int ndots);
        exp_t e;
        for (int k = 0; k < ndots; k++) begin
            for (int p = 0; p < NP; p++) begin
                e.l[p] = d[p*W + k];
                e.m[p] = d[p*W + W - 1 - k];
            end
            sb.push_back(e);
            if (wide) sb.push_back(e);
        end
    endtask

    task automatic clear_urun();
        nHBLANK = 1'b0;
        UCLR = 1'b1;
        tick();
        UCLR = 1'b0;
    endtask

    task automatic run_active(input int n, input bit end_blank);
        exp_t e;
        nHBLANK = 1'b1;
        for (int i = 0; i < n; i++) begin
            #4;
            e = (sb.size() > 0) ? sb.pop_front() : exp_t'(0);
            checks += 2;
            if (GDAT !== e.l) begin
                failures++;
                $display("FAIL gdat_lsb dot%0d: got %b required %b", i, GDAT, e.l);
            end
            if (GDAT_M !== e.m) begin
                failures++;
                $display("FAIL gdat_msb dot%0d: got %b required %b", i, GDAT_M, e.m);
            end
            if (i == n - 1 && end_blank) nHBLANK = 1'b0;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [NP*W-1:0] wa, wb;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        #4;
        checks += 3;
        if (GDAT !== '0 || GDAT_M !== '0) begin
            failures++;
            $display("FAIL reset_gdat: got %b/%b required 000", GDAT, GDAT_M);
        end
        if (DRDY !== 1'b1) begin
            failures++;
            $display("FAIL reset_drdy: got %b required 1", DRDY);
        end
        if (UNDERRUN !== 1'b0) begin
            failures++;
            $display("FAIL reset_urun: got %b required 0", UNDERRUN);
        end
        tick();
        sb.delete();
        wa = 24'hFF_FF_FF;
        wb = 24'h12_34_56;
        load_word(wa);
        load_word(wb);
        tick();
        push_dots(wa, 1'b0, 3);
        run_active(3, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #4;
        checks += 3;
        if (GDAT !== '0 || GDAT_M !== '0) begin
            failures++;
            $display("FAIL midreset_gdat: got %b/%b required 000", GDAT, GDAT_M);
        end
        if (DRDY !== 1'b1) begin
            failures++;
            $display("FAIL midreset_drdy: got %b required 1", DRDY);
        end
        if (UNDERRUN !== 1'b0) begin
            failures++;
            $display("FAIL midreset_urun: got %b required 0", UNDERRUN);
        end
        nHBLANK = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_lsb_words();
        logic [NP*W-1:0] w1, w2;
        sb.delete();
        clear_urun();
        w1 = {8'h0F, 8'h5A, 8'hA5};
        w2 = {8'hF0, 8'hC3, 8'h3C};
        load_word(w1);
        load_word(w2);
        tick();
        push_dots(w1, 1'b0, W);
        push_dots(w2, 1'b0, W);
        run_active(2*W, 1'b1);
        #4;
        checks++;
        if (UNDERRUN !== 1'b0 || GDAT !== '0) begin
            failures++;
            $display("FAIL lsb_words_end: urun=%b gdat=%b required 0/000", UNDERRUN, GDAT);
        end
        tick();
    endtask

    task automatic test_wide();
        logic [NP*W-1:0] w;
        sb.delete();
        clear_urun();
        DWIDE = 1'b1;
        tick();
        w = {8'h00, 8'h00, 8'h81};
        load_word(w);
        tick();
        push_dots(w, 1'b1, W);
        run_active(2*W, 1'b1);
        #4;
        checks++;
        if (UNDERRUN_M !== 1'b0) begin
            failures++;
            $display("FAIL wide_urun: got %b required 0", UNDERRUN_M);
        end
        DWIDE = 1'b0;
        @(posedge CLK);
        #1;
        tick();
    endtask

    task automatic test_underrun();
        logic [NP*W-1:0] w;
        sb.delete();
        clear_urun();
        w = {8'h3C, 8'hE7, 8'h99};
        load_word(w);
        tick();
        push_dots(w, 1'b0, W);
        run_active(W, 1'b0);
        #4;
        checks += 2;
        if (UNDERRUN !== 1'b1 || UNDERRUN_M !== 1'b1) begin
            failures++;
            $display("FAIL urun_set: got %b/%b required 1", UNDERRUN, UNDERRUN_M);
        end
        if (GDAT !== '0 || GDAT_M !== '0) begin
            failures++;
            $display("FAIL urun_gdat: got %b/%b required 000", GDAT, GDAT_M);
        end
        @(posedge CLK);
        #1;
        UCLR = 1'b1;
        tick();
        UCLR = 1'b0;
        #4;
        checks++;
        if (UNDERRUN !== 1'b0) begin
            failures++;
            $display("FAIL urun_clear: got %b required 0", UNDERRUN);
        end
        @(posedge CLK);
        #1;
        repeat (4) tick();
        UCLR = 1'b1;
        tick();
        UCLR = 1'b0;
        #4;
        checks++;
        if (UNDERRUN !== 1'b1) begin
            failures++;
            $display("FAIL urun_set_vs_clr: got %b required 1", UNDERRUN);
        end
        nHBLANK = 1'b0;
        @(posedge CLK);
        #1;
        UCLR = 1'b1;
        tick();
        UCLR = 1'b0;
        #4;
        checks++;
        if (UNDERRUN !== 1'b0) begin
            failures++;
            $display("FAIL urun_blank_clear: got %b required 0", UNDERRUN);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [NP*W-1:0] w[5];
        exp_t e;
        logic exp_rdy;
        sb.delete();
        clear_urun();
        for (int i = 0; i < 5; i++) w[i] = (NP*W)'($urandom());
        load_word(w[0]);
        load_word(w[1]);
        tick();
        push_dots(w[0], 1'b0, W);
        push_dots(w[1], 1'b0, W);
        DATA   = w[2];
        DVALID = 1'b1;
        push_dots(w[2], 1'b0, W);
        nHBLANK = 1'b1;
        for (int c = 0; c < 5*W; c++) begin
            #4;
            e = (sb.size() > 0) ? sb.pop_front() : exp_t'(0);
            if (c < 3*W)      exp_rdy = ((c % W) == W - 1);
            else if (c < 4*W) exp_rdy = (c == 4*W - 1);
            else              exp_rdy = 1'b1;
            checks += 3;
            if (GDAT !== e.l) begin
                failures++;
                $display("FAIL b2b_gdat_lsb dot%0d: got %b required %b", c, GDAT, e.l);
            end
            if (GDAT_M !== e.m) begin
                failures++;
                $display("FAIL b2b_gdat_msb dot%0d: got %b required %b", c, GDAT_M, e.m);
            end
            if (DRDY !== exp_rdy) begin
                failures++;
                $display("FAIL b2b_drdy dot%0d: got %b required %b", c, DRDY, exp_rdy);
            end
            if (c == 5*W - 1) nHBLANK = 1'b0;
            @(posedge CLK);
            #1;
            if (c == W - 1) begin
                DATA = w[3];
                push_dots(w[3], 1'b0, W);
            end else if (c == 2*W - 1) begin
                DATA = w[4];
                push_dots(w[4], 1'b0, W);
            end else if (c == 3*W - 1) begin
                DVALID = 1'b0;
            end
        end
        #4;
        checks++;
        if (UNDERRUN !== 1'b0) begin
            failures++;
            $display("FAIL b2b_urun: got %b required 0", UNDERRUN);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_blank_mid();
        logic [NP*W-1:0] wa, wb;
        sb.delete();
        clear_urun();
        wa = {8'hFF, 8'hFF, 8'hFF};
        wb = {8'h6B, 8'hD2, 8'h1E};
        load_word(wa);
        load_word(wb);
        tick();
        push_dots(wa, 1'b0, 3);
        run_active(3, 1'b1);
        #4;
        checks++;
        if (GDAT !== '0 || GDAT_M !== '0) begin
            failures++;
            $display("FAIL mid_blank_gdat: got %b/%b required 000", GDAT, GDAT_M);
        end
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        #4;
        checks++;
        if (DRDY !== 1'b1) begin
            failures++;
            $display("FAIL mid_blank_drdy: got %b required 1", DRDY);
        end
        @(posedge CLK);
        #1;
        push_dots(wb, 1'b0, W);
        run_active(W, 1'b1);
        #4;
        checks++;
        if (UNDERRUN !== 1'b0) begin
            failures++;
            $display("FAIL mid_blank_urun: got %b required 0", UNDERRUN);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #1;
        test_reset();
        test_lsb_words();
        test_wide();
        test_underrun();
        test_back_to_back();
        test_blank_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gdout_mp.md
# gdout_mp

Multi-plane graphic serializer; parametrised successor of the single-plane dot shifter in the GVRAM video path. Accepts one `WORD`-bit word per plane through a valid/ready handshake into a one-deep hold register, primes its shifters during blanking, and shifts `NPLANE` dot streams out at dot clock or half dot clock. Owns its own dot counter, replacing the external `cnt` bus. Sits between the GVRAM read sequencer and the colour mixer.

## Interface
- `NPLANE`, 3: number of planes (1..8).
- `WORD`, 8: bits per plane word; power of two, 2..16.
- `LSB_FIRST`, 1: 1 shifts bit 0 out first; 0 shifts bit `WORD-1` first.
- `CLK  in  1`: dot clock (16 MHz). One clock; reset is synchronous and active-high.
- `RST  in  1`: synchronous, active-high reset.
- `nHBLANK  in  1`: low = horizontal blanking.
- `nVBLANK  in  1`: low = vertical blanking.
- `DWIDE  in  1`: 1 = each dot held 2 clocks (40-column mode); sampled only during blanking.
- `DATA  in  NPLANE*WORD`: plane p occupies bits [p*WORD +: WORD].
- `DVALID  in  1`: DATA valid.
- `DRDY  out  1`: hold register can accept; transfer on `DVALID & DRDY` at posedge.
- `UCLR  in  1`: clears `UNDERRUN`.
- `GDAT  out  NPLANE`: dot outputs, bit p = plane p.
- `UNDERRUN  out  1`: sticky; word boundary reached with hold empty.

## Operation
- `active = nHBLANK & nVBLANK`. Internal state: `hold[NPLANE]`, `hold_full`, `shreg[NPLANE]`, `primed`, `bitcnt` ($clog2(WORD) bits), `phase`, `wide_q`.
- Reset: hold, shreg, bitcnt, phase, wide_q cleared; `hold_full=0`, `primed=0`, `UNDERRUN=0`. Outputs after reset: `GDAT=0`, `DRDY=1`, `UNDERRUN=0`.
- `DRDY = !hold_full | take`, where `take` = hold consumed by shifter this cycle. Accept and take in the same cycle: hold reloads with new DATA, `hold_full` stays 1.
- Blanking (`!active`): bitcnt=0, phase=0, `wide_q<=DWIDE`. If `!primed & hold_full`: shreg<=hold, primed=1, take. Otherwise shreg holds. Hold persists across blanking (prefetch for the next line).
- Active entry from a line: the first active clock shows the primed bit 0 / bit `WORD-1`. If not primed, GDAT=0 for that word and UNDERRUN sets on the first active clock.
- Active, `step = !wide_q | phase`; phase toggles each active clock when `wide_q=1`, else stays 0.
- On step with bitcnt≠WORD-1: shreg shifts toward the output end (zero fill), bitcnt+1 (wraps).
- On step with bitcnt=WORD-1: if hold_full, shreg<=hold, take, primed=1; else shreg<=0, primed=0, UNDERRUN<=1. bitcnt wraps to 0.
- Active→blank transition: the partial word is discarded; next blank clock clears primed, then the priming rule applies from the following clock.
- `UNDERRUN` set has priority over `UCLR` in the same cycle.
- `GDAT[p] = active & primed & shreg[p][LSB_FIRST ? 0 : WORD-1]` (combinational gate on blank; no shift register read outside active).
- `DWIDE` changes during active are ignored until the next blank.

## Timing
- Handshake accept at edge N → hold_full visible N+1; during blanking with shifter empty, shreg primed at edge N+1, hold freed (DRDY=1) after edge N+1.
- Active dot rate: one dot per clock (DWIDE=0), word every `WORD` clocks; one dot per 2 clocks (DWIDE=1), word every `2*WORD` clocks.
- Hold refill deadline: next word must be accepted before the edge ending the current word's last dot, or UNDERRUN.
- Blank-to-output latency 0: GDAT reflects shreg in the same cycle active rises.

## Structure
- Package `gdout_pkg`: default `NPLANE`/`WORD` constants, `BITCNT_W` function ($clog2 wrapper).
- Sub-module `gdout_plane`: one plane's hold + shift register + output tap, parameters `WORD`, `LSB_FIRST`, controlled by shared `load_hold`, `take`, `shift`, `clear` strobes. Top instantiates `NPLANE` copies plus control (bitcnt, phase, flags).

## Test plan
- Reset mid-line with hold full → next clock GDAT=0, DRDY=1, UNDERRUN=0, primed=0.
- WORD=8, LSB_FIRST=1, plane0 words 0xA5,0x3C loaded in blank; open active → GDAT[0] = 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; no UNDERRUN.
- LSB_FIRST=0, DWIDE=1, word 0x81 → GDAT[0]=1 for 2 clocks, 0 for 12 clocks, 1 for 2 clocks.
- Only one word supplied per line → after 8 dots GDAT=0, UNDERRUN=1 at boundary; stays 1 until UCLR; UNDERRUN and UCLR same cycle → remains 1.
- DVALID held high during active → accept and take coincide at every boundary, DRDY never drops at that edge, NPLANE=3 outputs match per-plane slices.
- nHBLANK dropped at dot 3 → GDAT=0 immediately, partial word discarded, hold word primes at blank and appears first on next line.
